// File: rtl/muldiv_ctl_pkg.sv
// rtl/muldiv_ctl_pkg.sv - shared decode constants, state encodings and magnitude helper for muldiv_ctl
package muldiv_ctl_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;

   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MTHI  = 6'b010001;
   localparam logic [5:0] FN_MFLO  = 6'b010010;
   localparam logic [5:0] FN_MTLO  = 6'b010011;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_DIVU  = 6'b011011;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_FIX  = 2'b10;

   // Two's-complement magnitude; -2^31 maps to 0x80000000 as an unsigned value.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one iteration of shift-add multiply or restoring divide
module muldiv_step (
   input  logic        is_div_i,
   input  logic [63:0] acc_i,
   input  logic [31:0] opnd_i,
   output logic [63:0] acc_o
);

   logic [32:0] sum;
   logic [32:0] rem_sh;
   logic [32:0] diff;

   // Multiply: acc = {partial product, remaining multiplier bits}.
   assign sum    = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, opnd_i} : 33'd0);
   // Divide: acc = {remainder, remaining dividend bits / quotient bits}.
   assign rem_sh = acc_i[63:31];
   assign diff   = rem_sh - {1'b0, opnd_i};

   always_comb begin
      acc_o = {sum, acc_i[31:1]};
      if (is_div_i) begin
         if (diff[32]) begin
            acc_o = {rem_sh[31:0], acc_i[30:0], 1'b0};
         end else begin
            acc_o = {diff[31:0], acc_i[30:0], 1'b1};
         end
      end
   end

endmodule

// File: rtl/muldiv_ctl.sv
// rtl/muldiv_ctl.sv - iterative mul/div sequencer owning HI/LO with EX-stage stall generation
module muldiv_ctl
   import muldiv_ctl_pkg::*;
#(
   parameter int ITER = 32,
   parameter int CW   = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] I2,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        stall_in,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        stall_out
);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [63:0]   acc_q, acc_d, acc_step;
   logic [31:0]   opnd_q, opnd_d;
   logic          is_div_q, is_div_d;
   logic          sa_q, sa_d, sb_q, sb_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d;

   logic [5:0]    fn;
   logic          is_special, is_md, is_hilo, op_signed, op_div;
   logic [31:0]   a_mag, b_mag;
   logic [63:0]   prod_fix;
   logic [31:0]   quot_fix, rem_fix;
   logic          unused_i2;

   assign fn         = I2[5:0];
   assign is_special = (I2[31:26] == OP_SPECIAL);
   assign is_md      = is_special && (fn inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
   assign is_hilo    = is_md || (is_special && (fn inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO}));
   assign unused_i2  = ^I2[25:6];

   assign op_signed  = (fn == FN_MULT) || (fn == FN_DIV);
   assign op_div     = (fn == FN_DIV) || (fn == FN_DIVU);
   assign a_mag      = mag32(rs_val, op_signed);
   assign b_mag      = mag32(rt_val, op_signed);

   assign prod_fix   = (sa_q ^ sb_q) ? (64'd0 - acc_q) : acc_q;
   assign quot_fix   = (sa_q ^ sb_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
   assign rem_fix    = sa_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

   assign busy       = (state_q != ST_IDLE);
   assign stall_out  = busy && is_hilo;
   assign hi         = hi_q;
   assign lo         = lo_q;

   muldiv_step u_step (
      .is_div_i (is_div_q),
      .acc_i    (acc_q),
      .opnd_i   (opnd_q),
      .acc_o    (acc_step)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      is_div_d = is_div_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (!stall_in) begin
               if (is_md) begin
                  is_div_d = op_div;
                  sa_d     = op_signed && rs_val[31];
                  sb_d     = op_signed && rt_val[31];
                  acc_d    = op_div ? {32'd0, a_mag} : {32'd0, b_mag};
                  opnd_d   = op_div ? b_mag : a_mag;
                  cnt_d    = CW'(ITER - 1);
                  state_d  = ST_RUN;
               end else if (is_special && fn == FN_MTHI) begin
                  hi_d = rs_val;
               end else if (is_special && fn == FN_MTLO) begin
                  lo_d = rs_val;
               end
            end
         end
         ST_RUN: begin
            acc_d = acc_step;
            if (cnt_q == '0) begin
               state_d = ST_FIX;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ST_FIX: begin
            if (is_div_q) begin
               hi_d = rem_fix;
               lo_d = quot_fix;
            end else begin
               hi_d = prod_fix[63:32];
               lo_d = prod_fix[31:0];
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         is_div_q <= 1'b0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         is_div_q <= is_div_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

endmodule
